bf16_unpacker: RTL and testbench

//  Inverse of the bf16 result normalizer. Accepts words of LANES packed bf16 values and emits one unpacked operand per cycle.

---
 rtl/tpu_fp_pkg.sv | 25 ++
 rtl/bf16_lane_decode.sv | 35 +++
 rtl/bf16_unpacker.sv | 123 ++++++++++++
 tb/tb_bf16_unpacker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_fp_pkg.sv
// Shared bf16 field widths and operand structs for the TPU floating-point datapath.
package tpu_fp_pkg;

  localparam int unsigned BF16_EXP_W  = 8;
  localparam int unsigned BF16_FRAC_W = 7;
  localparam int unsigned BF16_BIAS   = 127;
  localparam logic [BF16_EXP_W-1:0] BF16_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                   sign;
    logic [BF16_EXP_W-1:0]  exp;
    logic [BF16_FRAC_W-1:0] frac;
  } bf16_t;

  // exp is one bit wider than bf16 so it lines up with the normalizer's exp_in.
  typedef struct packed {
    logic       sign;
    logic [8:0] exp;
    logic [7:0] mant;
    logic       zero;
    logic       inf;
    logic       nan;
  } fp_unpacked_t;

endpackage

// File: rtl/bf16_lane_decode.sv
// Combinational decode of one bf16 value into sign / 9-bit exponent / 1.7 mantissa / class flags.
// Define BF16_UNPACK_DENORM_EN to keep subnormals exact instead of flushing them to zero.
module bf16_lane_decode
  import tpu_fp_pkg::*;
(
  input  bf16_t        operand,
  output fp_unpacked_t unpacked
);

  always_comb begin
    unpacked      = '0;
    unpacked.sign = operand.sign;
    if (operand.exp == '0) begin
`ifdef BF16_UNPACK_DENORM_EN
      // Subnormal: 0.f * 2^(1-bias), so the hidden bit is 0 and the exponent is 1.
      if (operand.frac != '0) begin
        unpacked.exp  = 9'd1;
        unpacked.mant = {1'b0, operand.frac};
      end else begin
        unpacked.zero = 1'b1;
      end
`else
      unpacked.zero = 1'b1;
`endif
    end else begin
      unpacked.exp  = {1'b0, operand.exp};
      unpacked.mant = {1'b1, operand.frac};
      if (operand.exp == BF16_EXP_MAX) begin
        unpacked.inf = (operand.frac == '0);
        unpacked.nan = (operand.frac != '0);
      end
    end
  end

endmodule

// File: rtl/bf16_unpacker.sv
// Buffers one word of LANES packed bf16 values and hands out one decoded operand per cycle.
// Subnormal handling follows BF16_UNPACK_DENORM_EN (see bf16_lane_decode).
module bf16_unpacker
  import tpu_fp_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [8:0]            out_exp,
  output logic [7:0]            out_mant,
  output logic                  out_zero,
  output logic                  out_inf,
  output logic                  out_nan,
  output logic                  out_last,
  output logic [CNT_W-1:0]      elem_count
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [16*LANES-1:0] buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]    lane_idx_q, lane_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic         is_last;
  logic         accept;
  logic         handoff;
  bf16_t        cur_lane;
  fp_unpacked_t dec;

  assign is_last  = (lane_idx_q == LAST_IDX);
  assign in_ready = !flush && (!buf_valid_q || (out_ready && is_last));
  assign accept   = in_valid && in_ready;
  assign handoff  = buf_valid_q && out_ready;

  always_comb begin
    cur_lane = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_idx_q == IDX_W'(i)) begin
        cur_lane = buf_q[16*i +: 16];
      end
    end
  end

  bf16_lane_decode u_decode (
    .operand  (cur_lane),
    .unpacked (dec)
  );

  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    lane_idx_d  = lane_idx_q;
    cnt_d       = cnt_q;
    if (flush) begin
      // A flush also swallows any handshake offered in the same cycle.
      buf_valid_d = 1'b0;
      lane_idx_d  = '0;
    end else begin
      if (handoff) begin
        cnt_d = cnt_q + 1'b1;
        if (is_last) begin
          buf_valid_d = 1'b0;
          lane_idx_d  = '0;
        end else begin
          lane_idx_d = lane_idx_q + 1'b1;
        end
      end
      if (accept) begin
        buf_d       = in_data;
        buf_valid_d = 1'b1;
        lane_idx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      lane_idx_q  <= '0;
      cnt_q       <= '0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      lane_idx_q  <= lane_idx_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    out_valid = buf_valid_q;
    out_sign  = 1'b0;
    out_exp   = '0;
    out_mant  = '0;
    out_zero  = 1'b0;
    out_inf   = 1'b0;
    out_nan   = 1'b0;
    out_last  = 1'b0;
    if (buf_valid_q) begin
      out_sign = dec.sign;
      out_exp  = dec.exp;
      out_mant = dec.mant;
      out_zero = dec.zero;
      out_inf  = dec.inf;
      out_nan  = dec.nan;
      out_last = is_last;
    end
  end

  assign elem_count = cnt_q;

endmodule

// File: tb/tb_bf16_unpacker.sv
// Scoreboard bench for bf16_unpacker: directed words then randomized traffic with flush/reset.
module tb_bf16_unpacker;

  localparam int LANES = 2;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sign;
  logic [8:0]        out_exp;
  logic [7:0]        out_mant;
  logic              out_zero;
  logic              out_inf;
  logic              out_nan;
  logic              out_last;
  logic [CNT_W-1:0]  elem_count;

  bf16_unpacker #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_mant   (out_mant),
    .out_zero   (out_zero),
    .out_inf    (out_inf),
    .out_nan    (out_nan),
    .out_last   (out_last),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sign;
    logic [8:0] exp;
    logic [7:0] mant;
    logic       zero;
    logic       inf;
    logic       nan;
    logic       last;
  } op_t;

  op_t         sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] model_count = '0;
  bit          last_acc = 1'b0;

  // Value-level bf16 classification: sign, biased exponent, 1.7 significand.
  function automatic op_t model(logic [15:0] h, bit last);
    op_t r;
    int  e;
    int  f;
    e      = int'(h[14:7]);
    f      = int'(h[6:0]);
    r      = '0;
    r.sign = h[15];
    r.last = last;
    if (e == 0) begin
`ifdef BF16_UNPACK_DENORM_EN
      if (f != 0) begin
        r.exp  = 9'd1;
        r.mant = 8'(f);
      end else begin
        r.zero = 1'b1;
      end
`else
      r.zero = 1'b1;
`endif
    end else begin
      r.exp  = 9'(e);
      r.mant = 8'(128 + f);
      if (e == 255) begin
        r.inf = (f == 0);
        r.nan = (f != 0);
      end
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // One clock of stimulus; expected lanes enter the scoreboard when the word is taken.
  task automatic cyc(bit v, logic [31:0] d, bit ordy, bit fl, bit r);
    bit acc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    acc = v && in_ready && !r;
    last_acc = acc;
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        sb.push_back(model(d[16*i +: 16], i == LANES - 1));
      end
    end
  endtask

  // Monitor: compares the presented operand against the scoreboard head each cycle.
  initial begin
    op_t got;
    bit  want_ready;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        sb.delete();
        model_count = '0;
      end else begin
        got = {out_sign, out_exp, out_mant, out_zero, out_inf, out_nan, out_last};
        want_ready = !flush && (sb.size() == 0 || (out_ready && sb.size() == 1));
        check("in_ready", 32'(in_ready), 32'(want_ready));
        check("elem_count", 32'(elem_count), 32'(model_count));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && sb.size() != 0) begin
          check("operand", 32'(got), 32'(sb[0]));
          if (!flush && out_ready) begin
            void'(sb.pop_front());
            model_count = model_count + 16'd1;
          end
        end else if (!out_valid) begin
          check("idle_outputs", 32'(got), 32'd0);
        end
        if (flush) sb.delete();
      end
    end
  end

  function automatic logic [15:0] rand_lane();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom % 4)
      0: h[14:7] = 8'h00;
      1: h[14:7] = 8'hFF;
      default: ;
    endcase
    return h;
  endfunction

  initial begin
    int          sent;
    int          cycles;
    logic [31:0] words [4];
    words[0] = 32'h4049_3F80;
    words[1] = 32'hBF80_0000;
    words[2] = 32'h7F80_FF81;
    words[3] = 32'h0001_C120;

    repeat (3) cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0);

    // Normal values, then inf/nan, then zero and subnormal.
    cyc(1, 32'hC000_3F80, 1, 0, 0);
    repeat (3) cyc(0, '0, 1, 0, 0);
    cyc(1, 32'hFFC1_7F80, 1, 0, 0);
    repeat (3) cyc(0, '0, 1, 0, 0);
    cyc(1, 32'h0000_8001, 1, 0, 0);
    repeat (3) cyc(0, '0, 1, 0, 0);

    // Stall with a word waiting upstream.
    cyc(1, 32'h4120_C0A0, 1, 0, 0);
    repeat (3) cyc(1, 32'h1234_5678, 0, 0, 0);
    repeat (4) cyc(0, '0, 1, 0, 0);

    // Back-to-back stream: 4 words should go in over 7 cycles with no bubble.
    sent = 0;
    cycles = 0;
    while (sent < 4 && cycles < 20) begin
      cyc(1, words[sent], 1, 0, 0);
      cycles++;
      if (last_acc) sent++;
    end
    check("stream_accepts", 32'(sent), 32'd4);
    check("stream_cycles", 32'(cycles), 32'd7);
    repeat (3) cyc(0, '0, 1, 0, 0);

    // Flush after the first lane, then reset mid-word.
    cyc(1, 32'h4000_4040, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 1, 0);
    repeat (2) cyc(0, '0, 1, 0, 0);
    cyc(1, 32'h3F80_4080, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 1);
    repeat (2) cyc(0, '0, 1, 0, 0);

    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom % 3) != 0, {rand_lane(), rand_lane()}, ($urandom % 4) != 0,
          ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    repeat (4) cyc(0, '0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
